// File: rtl/if_prefetch_queue_if.sv
// if_prefetch_queue_if: redirect/stall control, instruction SRAM handshake and decode handshake of the fetch queue.
interface if_prefetch_queue_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_stall;
    logic        inst_sram_req;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        fs_to_ds_valid;
    logic        ds_allow_in;
    logic [64:0] fs_to_ds_bus;
    modport master (
        input  redirect_valid, redirect_pc, fetch_stall,
        input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata, ds_allow_in,
        output inst_sram_req, inst_sram_addr, fs_to_ds_valid, fs_to_ds_bus
    );
    modport slave (
        output redirect_valid, redirect_pc, fetch_stall,
        output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata, ds_allow_in,
        input  inst_sram_req, inst_sram_addr, fs_to_ds_valid, fs_to_ds_bus
    );
endinterface

// File: rtl/if_prefetch_queue.sv
// if_prefetch_queue: multi-outstanding instruction fetch with a DEPTH-entry FIFO and counter-based redirect discard.
// Define IF_PREFETCH_BYPASS_EN to hand a response to decode in its data_ok cycle when the FIFO is empty.
module if_prefetch_queue #(
    parameter int          DEPTH     = 4,
    parameter int          MAX_OUTST = 2,
    parameter logic [31:0] RESET_PC  = 32'h1C000000
) (
    input logic clk,
    input logic reset,
    if_prefetch_queue_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam int QW = MAX_OUTST > 1 ? $clog2(MAX_OUTST) : 1;

    logic [31:0]   pc_req;
    logic [OW-1:0] outst, discard;
    logic [31:0]   pq [MAX_OUTST];
    logic [QW-1:0] pq_wr, pq_rd;
    logic [64:0]   fifo [DEPTH];
    logic [AW-1:0] wr, rd;
    logic [CW-1:0] count;
    logic          adef_halt;
    logic          aligned, req, issue, dok, keep, adef_push, bypass, push, pop;
    logic [64:0]   din;

    always_comb begin
        aligned = pc_req[1:0] == 2'b00;
        req = !reset && !bus.redirect_valid && !bus.fetch_stall && !adef_halt && aligned
            && 32'(outst) < 32'(MAX_OUTST) && 32'(count) + 32'(outst) < 32'(DEPTH);
        issue = req && bus.inst_sram_addr_ok;
        dok = bus.inst_sram_data_ok && outst != '0;
        keep = dok && discard == '0 && !bus.redirect_valid;
        adef_push = !adef_halt && !aligned && outst == '0 && discard == '0
            && 32'(count) < 32'(DEPTH) && !bus.redirect_valid;
`ifdef IF_PREFETCH_BYPASS_EN
        bypass = keep && count == '0;
`else
        bypass = 1'b0;
`endif
        din = adef_push ? {1'b1, 32'h0, pc_req} : {1'b0, bus.inst_sram_rdata, pq[pq_rd]};
        pop = count != '0 && bus.ds_allow_in && !bus.redirect_valid;
        push = adef_push || (keep && !(bypass && bus.ds_allow_in));
    end

    assign bus.inst_sram_req  = req;
    assign bus.inst_sram_addr = pc_req;
    assign bus.fs_to_ds_valid = count != '0 || bypass;
    assign bus.fs_to_ds_bus   = count != '0 ? fifo[rd] : bypass ? din : 65'b0;

    always_ff @(posedge clk) begin
        if (issue) pq[pq_wr] <= pc_req;
        if (push) fifo[wr] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_req    <= RESET_PC;
            outst     <= '0;
            discard   <= '0;
            pq_wr     <= '0;
            pq_rd     <= '0;
            wr        <= '0;
            rd        <= '0;
            count     <= '0;
            adef_halt <= 1'b0;
        end else begin
            if (issue) pq_wr <= pq_wr == QW'(MAX_OUTST - 1) ? '0 : pq_wr + 1'b1;
            if (dok) pq_rd <= pq_rd == QW'(MAX_OUTST - 1) ? '0 : pq_rd + 1'b1;
            outst <= outst + OW'(issue) - OW'(dok);
            // Every request still in flight after this cycle is stale; discard is always a subset of outst.
            discard <= bus.redirect_valid ? outst - OW'(dok) : discard - OW'(dok && discard != '0);
            pc_req <= bus.redirect_valid ? bus.redirect_pc : issue ? pc_req + 32'd4 : pc_req;
            adef_halt <= bus.redirect_valid ? 1'b0 : adef_halt | adef_push;
            if (bus.redirect_valid) begin
                wr    <= '0;
                rd    <= '0;
                count <= '0;
            end else begin
                if (push) wr <= wr + 1'b1;
                if (pop) rd <= rd + 1'b1;
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    assert property (@(posedge clk) disable iff (reset) !(bus.inst_sram_data_ok && outst == '0));
endmodule

// File: tb/tb_if_prefetch_queue.sv
// tb_if_prefetch_queue: randomized SRAM/decode traffic against a queue-based fetch model, plus directed scenarios.
module tb_if_prefetch_queue;
    localparam int          DEPTH     = 4;
    localparam int          MAX_OUTST = 2;
    localparam logic [31:0] RESET_PC  = 32'h1C000000;
`ifdef IF_PREFETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic        stale;
    } ent_t;

    logic clk = 1'b0;
    logic reset;
    if_prefetch_queue_if sif();
    if_prefetch_queue #(.DEPTH(DEPTH), .MAX_OUTST(MAX_OUTST), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset), .bus(sif)
    );
    always #5 clk = ~clk;

    ent_t        oq[$];
    logic [64:0] fq[$];
    logic [64:0] got[$];
    logic [31:0] mpc;
    logic        mhalt;
    int          n_cmp = 0, n_bad = 0, cyc = 0, dcyc = -1, vcyc = -1;
    int          pa, pd, pal;
    logic        redir, stall, s_req, s_valid;
    logic [31:0] rpc, s_addr;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic step();
        logic        exp_req, exp_valid, byp, live, adef;
        logic [64:0] exp_bus, nw;
        ent_t        e;
        @(negedge clk);
        sif.inst_sram_addr_ok = 32'($urandom_range(99)) < 32'(pa);
        sif.inst_sram_data_ok = oq.size() > 0 && 32'($urandom_range(99)) < 32'(pd);
        sif.inst_sram_rdata   = sif.inst_sram_data_ok ? mem(oq[0].pc) : $urandom;
        sif.ds_allow_in       = 32'($urandom_range(99)) < 32'(pal);
        sif.redirect_valid    = redir;
        sif.redirect_pc       = rpc;
        sif.fetch_stall       = stall;
        #1;
        live = 1'b0;
        if (sif.inst_sram_data_ok) live = !oq[0].stale && !redir;
        exp_req = !redir && !stall && !mhalt && mpc[1:0] == 2'b00 && oq.size() < MAX_OUTST
            && fq.size() + oq.size() < DEPTH;
        adef = !redir && !mhalt && mpc[1:0] != 2'b00 && oq.size() == 0 && fq.size() < DEPTH;
        byp = BYP && live && fq.size() == 0;
        exp_valid = fq.size() > 0 || byp;
        nw = {1'b0, sif.inst_sram_rdata, oq.size() > 0 ? oq[0].pc : 32'h0};
        exp_bus = fq.size() > 0 ? fq[0] : nw;
        chk("req", 65'(sif.inst_sram_req), 65'(exp_req));
        chk("addr", 65'(sif.inst_sram_addr), 65'(mpc));
        chk("valid", 65'(sif.fs_to_ds_valid), 65'(exp_valid));
        if (exp_valid) chk("bus", sif.fs_to_ds_bus, exp_bus);
        s_req = sif.inst_sram_req;
        s_addr = sif.inst_sram_addr;
        s_valid = sif.fs_to_ds_valid;
        if (sif.fs_to_ds_valid && sif.ds_allow_in && !redir) got.push_back(sif.fs_to_ds_bus);
        if (sif.inst_sram_data_ok && dcyc < 0) dcyc = cyc;
        if (sif.fs_to_ds_valid && vcyc < 0) vcyc = cyc;
        if (redir) begin
            if (sif.inst_sram_data_ok) void'(oq.pop_front());
            foreach (oq[i]) oq[i].stale = 1'b1;
            fq.delete();
            mpc = rpc;
            mhalt = 1'b0;
        end else begin
            if (sif.inst_sram_data_ok) begin
                e = oq.pop_front();
                if (!e.stale) fq.push_back(nw);
            end
            if (adef) begin
                fq.push_back({1'b1, 32'h0, mpc});
                mhalt = 1'b1;
            end
            if (exp_valid && sif.ds_allow_in) void'(fq.pop_front());
            if (exp_req && sif.inst_sram_addr_ok) begin
                oq.push_back('{pc: mpc, stale: 1'b0});
                mpc = mpc + 32'd4;
            end
        end
        cyc++;
    endtask

    initial begin
        int b, g;
        reset = 1'b1;
        redir = 1'b0;
        stall = 1'b0;
        rpc = 32'h0;
        sif.redirect_valid = 1'b0;
        sif.redirect_pc = 32'h0;
        sif.fetch_stall = 1'b0;
        sif.inst_sram_addr_ok = 1'b0;
        sif.inst_sram_data_ok = 1'b0;
        sif.inst_sram_rdata = 32'h0;
        sif.ds_allow_in = 1'b0;
        mpc = RESET_PC;
        mhalt = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset_req", 65'(sif.inst_sram_req), 65'd0);
        chk("reset_addr", 65'(sif.inst_sram_addr), 65'h1C000000);
        chk("reset_valid", 65'(sif.fs_to_ds_valid), 65'd0);
        chk("reset_bus", sif.fs_to_ds_bus, 65'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        // Streaming: one-cycle SRAM, decode always ready.
        pa = 100; pd = 100; pal = 100;
        repeat (12) step();
        chk("stream_count", 65'(got.size()), BYP ? 65'd11 : 65'd10);
        chk("stream_latency", 65'(vcyc - dcyc), BYP ? 65'd0 : 65'd1);
        chk("stream_first", got.size() > 0 ? got[0] : 65'h0, {1'b0, mem(32'h1C000000), 32'h1C000000});
        chk("stream_fourth", got.size() > 3 ? got[3] : 65'h0, {1'b0, mem(32'h1C00000C), 32'h1C00000C});
        // Backpressure fills exactly DEPTH entries, then drains in order.
        pal = 0;
        repeat (10) step();
        chk("full_req", 65'(s_req), 65'd0);
        chk("full_valid", 65'(s_valid), 65'd1);
        b = got.size();
        pa = 0; pal = 100;
        repeat (6) step();
        chk("drain_count", 65'(got.size() - b), 65'(DEPTH));
        for (int i = 0; i < DEPTH; i++)
            if (b + i < got.size())
                chk("drain_order", 65'(got[b+i][31:0]), 65'(got[b-1][31:0] + 32'(4 * (i + 1))));
        // Redirect in the same cycle as the first of two responses.
        pa = 100; pd = 0;
        repeat (2) step();
        g = got.size();
        redir = 1'b1; rpc = 32'h1C001000; pd = 100;
        step();
        chk("redir_req", 65'(s_req), 65'd0);
        redir = 1'b0;
        step();
        chk("after_redir_req", 65'(s_req), 65'd1);
        chk("after_redir_addr", 65'(s_addr), 65'h1C001000);
        repeat (6) step();
        chk("redir_first", got.size() > g ? got[g] : 65'h0, {1'b0, mem(32'h1C001000), 32'h1C001000});
        // Misaligned redirect yields one adef entry and halts fetch.
        g = got.size();
        redir = 1'b1; rpc = 32'h1C000002;
        step();
        redir = 1'b0;
        repeat (6) step();
        chk("adef_count", 65'(got.size() - g), 65'd1);
        chk("adef_entry", got.size() > g ? got[g] : 65'h0, {1'b1, 32'h0, 32'h1C000002});
        chk("adef_halt_req", 65'(s_req), 65'd0);
        // Stall with one request in flight.
        redir = 1'b1; rpc = 32'h1C000100;
        step();
        redir = 1'b0; pd = 0;
        step();
        g = got.size();
        stall = 1'b1; pd = 100;
        repeat (4) begin
            step();
            chk("stall_req", 65'(s_req), 65'd0);
        end
        stall = 1'b0;
        chk("stall_count", 65'(got.size() - g), 65'd1);
        chk("stall_entry", got.size() > g ? got[g] : 65'h0, {1'b0, mem(32'h1C000100), 32'h1C000100});
        // Address wrap through 2^32.
        redir = 1'b1; rpc = 32'hFFFFFFF8;
        step();
        redir = 1'b0;
        repeat (8) step();
        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            if (n % 50 == 0) begin
                pa = 20 + int'($urandom_range(80));
                pd = 20 + int'($urandom_range(80));
                pal = int'($urandom_range(100));
            end
            redir = $urandom_range(99) < 4;
            stall = $urandom_range(99) < 10;
            rpc = 32'h1C000000 + 32'($urandom_range(1023)) * 32'd4
                + ($urandom_range(9) == 0 ? 32'($urandom_range(3)) : 32'd0);
            step();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
